// File: rtl/cpu24_pkg.sv
// Shared definitions for the 24-bit CPU datapath blocks: data width,
// sequencer state encoding and the ADD/SUB opcode bit.
package cpu24_pkg;

    localparam int DATA_W = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_24_if.sv
// Start/done handshake and operand/result bus between the control unit
// (master) and the bit-serial adder (slave).
interface serial_adder_24_if #(
    parameter int WIDTH = 24
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  ready, done, result, cout, overflow, zero
    );

    modport slave (
        input  start, op, a, b,
        output ready, done, result, cout, overflow, zero
    );
endinterface

// File: rtl/Mbledhesi1bit.sv
// 1-bit full-adder cell used as the arithmetic core of the serial adder.
module Mbledhesi1bit (
    input  logic A,
    input  logic B,
    input  logic CIN,
    output logic Shuma,
    output logic COUT
);
    assign Shuma = A ^ B ^ CIN;
    assign COUT  = (A & B) | (CIN & (A ^ B));
endmodule

// File: rtl/serial_adder_24.sv
// Bit-serial adder/subtractor: one operand bit pair per clock through a single
// full-adder cell, carry held in a flop, result assembled in a shift register.
module serial_adder_24
    import cpu24_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_24_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sra_q, sra_d;
    logic [WIDTH-1:0]   srb_q, srb_d;
    logic [WIDTH-1:0]   res_sr_q, res_sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               overflow_q, overflow_d;
    logic               zero_q, zero_d;

    logic               fa_sum;
    logic               fa_cout;

    Mbledhesi1bit u_fa (
        .A     (sra_q[0]),
        .B     (srb_q[0]),
        .CIN   (carry_q),
        .Shuma (fa_sum),
        .COUT  (fa_cout)
    );

    always_comb begin
        state_d    = state_q;
        sra_d      = sra_q;
        srb_d      = srb_q;
        res_sr_d   = res_sr_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        ready_d    = ready_q;
        done_d     = done_q;
        result_d   = result_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;

        unique case (state_q)
            IDLE: begin
                done_d = 1'b0;
                ready_d = 1'b1;
                if (bus.start) begin
                    // Subtraction is A + ~B + 1: invert B and preload the carry.
                    sra_d   = bus.a;
                    srb_d   = (bus.op == OP_SUB) ? ~bus.b : bus.b;
                    carry_d = bus.op;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_sr_d = {fa_sum, res_sr_q[WIDTH-1:1]};
                sra_d    = sra_q >> 1;
                srb_d    = srb_q >> 1;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // carry_q here is the carry into the MSB, so overflow needs no extra flop.
                    result_d   = res_sr_d;
                    cout_d     = fa_cout;
                    overflow_d = carry_q ^ fa_cout;
                    zero_d     = (res_sr_d == '0);
                    done_d     = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                done_d  = 1'b0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sra_q      <= '0;
            srb_q      <= '0;
            res_sr_q   <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sra_q      <= sra_d;
            srb_q      <= srb_d;
            res_sr_q   <= res_sr_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            result_q   <= result_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = overflow_q;
    assign bus.zero     = zero_q;

endmodule
